fifo_sync_flags: RTL and testbench
==================================

Name: fifo_sync_flags

Overview:
- Parametrised successor to the team's shift-register FIFO: single-clock circular-buffer FIFO with first-word-fall-through read.
- Adds occupancy level output, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a synchronous flush.
- Sits between producer and consumer blocks in the data path, using the same write/read/val/full handshake as existing FIFOs.

Parameters:
- DEPTH, 16, number of entries; any integer >= 2 (power of two not required).
- DATA_WIDTH, 8, entry width in bits.
- AF_THRESH, DEPTH-2, almost_full asserts when level >= AF_THRESH; legal range 1..DEPTH.
- AE_THRESH, 2, almost_empty asserts when level <= AE_THRESH; legal range 0..DEPTH-1.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- clear  in  1  synchronous flush: empties FIFO and clears error flags.
- write  in  1  write request.
- datain  in  DATA_WIDTH  write data.
- read  in  1  read/pop request; head entry is consumed at the clock edge.
- dataout  out  DATA_WIDTH  head entry (fall-through); forced to 0 when val=0.
- val  out  1  FIFO non-empty; dataout is valid.
- full  out  1  level == DEPTH.
- almost_full  out  1  level >= AF_THRESH.
- almost_empty  out  1  level <= AE_THRESH.
- level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was dropped.
- underflow  out  1  sticky: a read was issued while empty.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-low on reset_n.
- Priority per edge: reset_n=0 > clear=1 > normal operation.
- Reset and clear values:
  - wr_ptr=0, rd_ptr=0, level=0.
  - val=0, full=0, dataout=0, almost_empty=1, almost_full=0.
  - overflow=0, underflow=0.
  - Storage array is not reset.
- clear has the same effect as reset. Any write or read in the same cycle is ignored and does not set error flags.
- Effective operations:
  - do_wr = write & (!full | read).
  - do_rd = read & val.
- do_wr: mem[wr_ptr] <= datain; wr_ptr advances.
- do_rd: rd_ptr advances.
- Level update: +1 on do_wr only; -1 on do_rd only; unchanged when both occur.
- Pointer wrap: a pointer at DEPTH-1 advances to 0. Explicit compare, no power-of-two masking.
- Latency:
  - A word written into an empty FIFO appears on dataout, with val=1, the cycle after the write edge.
  - No same-cycle bypass from datain to dataout.
- Full and read+write: both occur. The head is popped and the new word is stored in the freed slot. level stays DEPTH; full stays 1.
- Empty and read+write: write only. underflow is set; level becomes 1.
- Overflow: write & full & !read sets overflow. Data is dropped; pointers and level are unchanged.
- Underflow: read & !val sets underflow. No state change.
- Sticky flags hold until reset or clear.
- Flag timing: all flags (full, val, almost_*) derive combinationally from the registered level. They change in the cycle after the edge that changes level.
- dataout = val ? mem[rd_ptr] : 0.
- Behaviour with parameters outside the legal ranges is undefined. Simulation asserts flag illegal values at elaboration.

Decomposition:
- Shared package fifo_pkg:
  - function clog2_lvl(depth), returning the level width.
  - Default parameter constants FIFO_DEPTH_DEF and FIFO_WIDTH_DEF.
- One sub-module, fifo_ram:
  - DEPTH x DATA_WIDTH storage.
  - Synchronous write port (we, waddr, wdata); asynchronous read port (raddr, rdata).
- The top level holds pointers, level counter, flags and sticky errors.

Test Plan:
- Reset/flags: DEPTH=16, AF=14, AE=2. Hold reset_n=0 for 2 cycles with write=1 -> level=0, val=0, dataout=0, almost_empty=1, no flags set.
- Fill/drain order: write 0x01..0x10 (16 words) -> full=1, level=16, almost_full asserted at level 14. Then read 16 words -> dataout sequence 0x01..0x10, val=0 after the last read, almost_empty asserted at level 2.
- Wrap-around: DEPTH=5. Write 3, read 3, write 5 (0xA0..0xA4) -> full=1, reads return 0xA0..0xA4 in order across the pointer wrap.
- Simultaneous ops:
  - Full with read+write of 0x55 -> level stays 16, 0x55 read last.
  - Empty with read+write of 0x66 -> level=1, underflow=1, dataout=0x66 next cycle.
- Errors: write when full without read -> overflow=1, level=16, contents unchanged. Read when empty -> underflow=1. Both flags persist until clear=1 for one cycle, after which both are 0 and level=0.
- Clear mid-operation: level=7 with write=1 and clear=1 -> next cycle level=0, val=0. The written word is never observed.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the flagged synchronous FIFO.
package fifo_pkg;

    localparam int FIFO_DEPTH_DEF = 16;
    localparam int FIFO_WIDTH_DEF = 8;

    // Width needed to hold an occupancy count of 0..depth inclusive.
    function automatic int clog2_lvl(input int depth);
        int w;
        w = 0;
        while ((1 << w) < depth) w++;
        return w + 1;
    endfunction

endpackage

// File: rtl/fifo_sync_flags_if.sv
// Producer/consumer handshake bundle for fifo_sync_flags.
interface fifo_sync_flags_if
    import fifo_pkg::*;
#(
    parameter int DEPTH      = FIFO_DEPTH_DEF,
    parameter int DATA_WIDTH = FIFO_WIDTH_DEF
);
    localparam int LW = clog2_lvl(DEPTH);

    logic                  clear;
    logic                  write;
    logic [DATA_WIDTH-1:0] datain;
    logic                  read;
    logic [DATA_WIDTH-1:0] dataout;
    logic                  val;
    logic                  full;
    logic                  almost_full;
    logic                  almost_empty;
    logic [LW-1:0]         level;
    logic                  overflow;
    logic                  underflow;

    // Client side: drives requests, observes status.
    modport master (
        output clear, write, datain, read,
        input  dataout, val, full, almost_full, almost_empty, level, overflow, underflow
    );

    // FIFO side.
    modport slave (
        input  clear, write, datain, read,
        output dataout, val, full, almost_full, almost_empty, level, overflow, underflow
    );
endinterface

// File: rtl/fifo_ram.sv
// DEPTH x DATA_WIDTH storage: synchronous write, asynchronous read. Not reset.
module fifo_ram #(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 8,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [AW-1:0]         i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]         i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Store the incoming word on an accepted write.
    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/fifo_sync_flags.sv
// Single-clock circular-buffer FIFO, first-word-fall-through, with level,
// programmable almost flags, sticky overflow/underflow and synchronous flush.
module fifo_sync_flags
    import fifo_pkg::*;
#(
    parameter int DEPTH      = FIFO_DEPTH_DEF,
    parameter int DATA_WIDTH = FIFO_WIDTH_DEF,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    fifo_sync_flags_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = clog2_lvl(DEPTH);

    if (DEPTH < 2 || AF_THRESH < 1 || AF_THRESH > DEPTH ||
        AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_params
        $error("fifo_sync_flags: illegal DEPTH/AF_THRESH/AE_THRESH");
    end

    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [LW-1:0]         r_level;
    logic                  r_overflow;
    logic                  r_underflow;
    logic                  w_val;
    logic                  w_full;
    logic                  w_do_wr;
    logic                  w_do_rd;
    logic                  w_we;
    logic [DATA_WIDTH-1:0] w_rdata;

    // Pointer increment with explicit wrap so DEPTH need not be a power of two.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign w_val   = (r_level != '0);
    assign w_full  = (r_level == LW'(DEPTH));
    // A read on a full FIFO frees the head slot, so the write may proceed.
    assign w_do_wr = bus.write & (~w_full | bus.read);
    assign w_do_rd = bus.read & w_val;
    // Suppress the RAM write during reset/flush so nothing lands behind the pointers.
    assign w_we    = w_do_wr & i_reset_n & ~bus.clear;

    fifo_ram #(.DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH), .AW(AW)) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (bus.datain),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    // Pointers, occupancy and sticky errors; reset and flush behave identically.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n || bus.clear) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_do_wr) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_do_rd) r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_do_wr, w_do_rd})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
            if (bus.write & w_full & ~bus.read) r_overflow  <= 1'b1;
            if (bus.read & ~w_val)              r_underflow <= 1'b1;
        end
    end

    assign bus.dataout      = w_val ? w_rdata : '0;
    assign bus.val          = w_val;
    assign bus.full         = w_full;
    assign bus.almost_full  = (r_level >= LW'(AF_THRESH));
    assign bus.almost_empty = (r_level <= LW'(AE_THRESH));
    assign bus.level        = r_level;
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;
endmodule

// File: tb/tb_fifo_sync_flags.sv
// Drives a DEPTH=16 and a DEPTH=5 FIFO with the same stimulus and compares
// both against queue-based reference models.
module tb_fifo_sync_flags;
    logic       clk = 1'b0;
    logic       rstn, clr, wr, rd;
    logic [7:0] din;

    int checks = 0;
    int errors = 0;

    int DEP [2] = '{16, 5};
    int AFT [2] = '{14, 3};
    int AET [2] = '{2, 2};

    logic [7:0] mq [2][$];
    bit         m_ovf [2];
    bit         m_udf [2];

    always #5 clk = ~clk;

    fifo_sync_flags_if #(.DEPTH(16), .DATA_WIDTH(8)) if16 ();
    fifo_sync_flags_if #(.DEPTH(5),  .DATA_WIDTH(8)) if5  ();

    assign if16.clear = clr;  assign if5.clear = clr;
    assign if16.write = wr;   assign if5.write = wr;
    assign if16.read  = rd;   assign if5.read  = rd;
    assign if16.datain = din; assign if5.datain = din;

    fifo_sync_flags #(.DEPTH(16), .DATA_WIDTH(8), .AF_THRESH(14), .AE_THRESH(2)) dut16 (
        .i_clk(clk), .i_reset_n(rstn), .bus(if16.slave));
    fifo_sync_flags #(.DEPTH(5), .DATA_WIDTH(8), .AF_THRESH(3), .AE_THRESH(2)) dut5 (
        .i_clk(clk), .i_reset_n(rstn), .bus(if5.slave));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference behaviour on one clock edge for FIFO i.
    task automatic model_step(input int i);
        int  n;
        bit  full_now;
        n = mq[i].size();
        full_now = (n == DEP[i]);
        if (!rstn || clr) begin
            mq[i].delete();
            m_ovf[i] = 0;
            m_udf[i] = 0;
        end else begin
            if (rd && n == 0) m_udf[i] = 1;
            if (wr && full_now && !rd) m_ovf[i] = 1;
            if (rd && n > 0) void'(mq[i].pop_front());
            if (wr && (!full_now || rd)) mq[i].push_back(din);
        end
    endtask

    task automatic check_dut(input int i);
        int         n;
        logic [7:0] exp_do;
        string      p;
        n      = mq[i].size();
        exp_do = (n > 0) ? mq[i][0] : 8'h00;
        p      = $sformatf("d%0d.", DEP[i]);
        if (i == 0) begin
            chk({p, "level"},   32'(if16.level),        32'(n));
            chk({p, "dataout"}, 32'(if16.dataout),      32'(exp_do));
            chk({p, "val"},     32'(if16.val),          32'(n > 0));
            chk({p, "full"},    32'(if16.full),         32'(n == DEP[i]));
            chk({p, "afull"},   32'(if16.almost_full),  32'(n >= AFT[i]));
            chk({p, "aempty"},  32'(if16.almost_empty), 32'(n <= AET[i]));
            chk({p, "ovf"},     32'(if16.overflow),     32'(m_ovf[i]));
            chk({p, "udf"},     32'(if16.underflow),    32'(m_udf[i]));
        end else begin
            chk({p, "level"},   32'(if5.level),        32'(n));
            chk({p, "dataout"}, 32'(if5.dataout),      32'(exp_do));
            chk({p, "val"},     32'(if5.val),          32'(n > 0));
            chk({p, "full"},    32'(if5.full),         32'(n == DEP[i]));
            chk({p, "afull"},   32'(if5.almost_full),  32'(n >= AFT[i]));
            chk({p, "aempty"},  32'(if5.almost_empty), 32'(n <= AET[i]));
            chk({p, "ovf"},     32'(if5.overflow),     32'(m_ovf[i]));
            chk({p, "udf"},     32'(if5.underflow),    32'(m_udf[i]));
        end
    endtask

    // Apply inputs for one clock, advance models, then sample after the edge.
    task automatic tick(input bit r_n, input bit c, input bit w, input bit r, input logic [7:0] d);
        rstn = r_n; clr = c; wr = w; rd = r; din = d;
        @(posedge clk);
        for (int i = 0; i < 2; i++) model_step(i);
        #1;
        for (int i = 0; i < 2; i++) check_dut(i);
    endtask

    initial begin
        rstn = 1'b0; clr = 1'b0; wr = 1'b0; rd = 1'b0; din = 8'h00;

        // Reset held with write asserted: nothing may be stored.
        tick(0, 0, 1, 0, 8'hAA);
        tick(0, 0, 1, 0, 8'hBB);
        chk("rst.level",  32'(if16.level), 0);
        chk("rst.aempty", 32'(if16.almost_empty), 1);

        // Fill 0x01..0x10; DEPTH=5 instance overflows along the way.
        for (int k = 1; k <= 16; k++) tick(1, 0, 1, 0, 8'(k));
        chk("fill.full",  32'(if16.full), 1);
        chk("fill.level", 32'(if16.level), 16);

        // Full with read+write: level holds, 0x55 goes to the tail.
        tick(1, 0, 1, 1, 8'h55);
        chk("rw_full.level", 32'(if16.level), 16);
        // Write while full, no read: dropped, overflow set.
        tick(1, 0, 1, 0, 8'hEE);
        chk("ovf.flag", 32'(if16.overflow), 1);

        // Drain 16 words; underflow follows on the extra read.
        for (int k = 0; k < 16; k++) tick(1, 0, 0, 1, 8'h00);
        chk("drain.val", 32'(if16.val), 0);
        tick(1, 0, 0, 1, 8'h00);
        chk("udf.flag", 32'(if16.underflow), 1);

        // Empty with read+write: write only.
        tick(1, 0, 1, 1, 8'h66);
        chk("rw_empty.dout", 32'(if16.dataout), 32'h66);
        chk("rw_empty.level", 32'(if16.level), 1);

        // Flush clears flags and contents.
        tick(1, 1, 0, 0, 8'h00);
        chk("clr.ovf", 32'(if16.overflow), 0);

        // Wrap-around: write 3, read 3, write 5, read 5.
        for (int k = 0; k < 3; k++) tick(1, 0, 1, 0, 8'(8'h30 + k));
        for (int k = 0; k < 3; k++) tick(1, 0, 0, 1, 8'h00);
        for (int k = 0; k < 5; k++) tick(1, 0, 1, 0, 8'(8'hA0 + k));
        chk("wrap.full5", 32'(if5.full), 1);
        for (int k = 0; k < 5; k++) begin
            chk("wrap.dout5", 32'(if5.dataout), 32'(8'hA0 + k));
            tick(1, 0, 0, 1, 8'h00);
        end

        // Clear mid-operation with a concurrent write.
        for (int k = 0; k < 7; k++) tick(1, 0, 1, 0, 8'(8'h70 + k));
        tick(1, 1, 1, 0, 8'h77);
        chk("clr_mid.level", 32'(if16.level), 0);
        chk("clr_mid.val",   32'(if16.val), 0);

        // Random traffic with shifting read/write bias to reach full and empty.
        for (int k = 0; k < 1500; k++) begin
            int wp;
            wp = ((k / 100) % 3 == 0) ? 80 : (((k / 100) % 3 == 1) ? 20 : 50);
            tick(($urandom_range(0, 299) != 0),
                 ($urandom_range(0, 79) == 0),
                 ($urandom_range(0, 99) < wp),
                 ($urandom_range(0, 99) < (100 - wp)),
                 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
